neural_network_2_layer: RTL and testbench
=========================================

Name: neural_network_2_layer

Overview:
- Two-layer fully-connected inference block (dense → ReLU → dense) on signed fixed-point data, one sample vector per beat.
- Sits between a feature source and a downstream classifier or decision stage.
- Weights come in as quasi-static configuration ports.
- Pipelined: 2-cycle latency, one sample per cycle throughput.

Parameters:
- IN_SIZE, 4: input vector length.
- HIDDEN1, 3: hidden-layer neuron count.
- OUT_SIZE, 2: output vector length.
- WIDTH, 16: bit width of every data and weight word (signed two's complement).
- FRAC, 8: fractional bits (Q(WIDTH-FRAC).FRAC; default Q8.8).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_vec holds a valid sample this cycle.
- in_vec  in  signed [WIDTH-1:0] unpacked [1][IN_SIZE]  input sample.
- W1  in  signed [WIDTH-1:0] unpacked [HIDDEN1][IN_SIZE]  layer-1 weights, row j feeds hidden neuron j.
- W2  in  signed [WIDTH-1:0] unpacked [OUT_SIZE][HIDDEN1]  layer-2 weights, row k feeds output k.
- out_valid  out  1  out_vec holds a new result.
- out_vec  out  signed [WIDTH-1:0] unpacked [1][OUT_SIZE]  inference result.

Behaviour:
- Hidden layer: h[j] = ReLU( (Σ_i W1[j][i]·in_vec[0][i]) >>> FRAC ).
- Output layer: out[k] = (Σ_j W2[k][j]·h[j]) >>> FRAC. The output layer has no activation.
- Arithmetic:
  - Products are full 2·WIDTH signed.
  - Accumulate at ACC_W = 2·WIDTH + $clog2(max(IN_SIZE,HIDDEN1)) + 1; no intermediate overflow.
  - Apply a single arithmetic right shift by FRAC after the full sum. This rounds toward −∞; no rounding offset is added.
  - Narrow to WIDTH by keeping the low WIDTH bits (wrap), unless NN_SAT_EN is defined.
- ReLU: result < 0 → 0, else unchanged. Applied after narrowing.
- Stage 1: on a rising clk edge with in_valid=1, register h[] and set h_valid=1. Otherwise h_valid=0 and h[] holds.
- Stage 2: on a rising clk edge with h_valid=1, register out_vec and set out_valid=1. Otherwise out_valid=0 and out_vec holds its last value.
- Latency and throughput:
  - out_valid rises exactly 2 clk edges after the edge that sampled in_valid.
  - Back-to-back in_valid yields back-to-back out_valid, in order.
  - No backpressure.
- Weight timing:
  - W1 is consumed combinationally in the in_valid cycle.
  - W2 is consumed in the h_valid cycle.
  - Weights must be held stable from in_valid until the matching out_valid. If weights change mid-flight, the result is defined only by the values present in each stage's sampling cycle.
- Reset (rst_n=0, async, independent of clk):
  - h[], h_valid, out_vec and out_valid are all cleared to 0.
  - In-flight samples are discarded.
  - First valid output comes 2 edges after the first post-reset in_valid.
- Boundaries:
  - All-zero input → all-zero output.
  - The most negative input (-2^(WIDTH-1)) is handled as a normal signed value.

Optional Feature:
- NN_SAT_EN defined: every narrowing to WIDTH (hidden pre-ReLU and output) saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- NN_SAT_EN undefined: low WIDTH bits are kept (two's-complement wrap).
- Both modes give identical results when no overflow occurs.

Decomposition:
- Package nn_pkg holds:
  - default WIDTH/FRAC constants;
  - an acc_width(n) function;
  - a sat_narrow function (behaviour selected by NN_SAT_EN);
  - a relu function.
- One sub-module: nn_dense_layer, parameters N_IN, N_OUT, WIDTH, FRAC, RELU.
  - Combinational matrix-vector product, shift and narrow, optional ReLU.
  - Instantiated twice (RELU=1 then RELU=0), with a pipeline register after each.

Test Plan:
- Common weight set, used for the first three scenarios, as raw Q8.8 integers:
  - W1 = {{-12,-47,11,65},{20,-18,21,3},{15,56,-4,23}}.
  - W2 = {{-5,-6,-17},{18,38,19}}.
- Sample 0: in_vec={256,512,768,1024} (1,2,3,4), one in_valid pulse.
  - Hidden = {187,59,207}.
  - 2 edges later out_valid=1, out_vec={-19,37} (≈-0.0742, 0.1445).
- Sample 1: in_vec={512,-256,0,768} (2,-1,0,3).
  - Hidden = {218,67,43}.
  - out_vec={-9,28} (≈-0.0352, 0.1094).
- ReLU clamp: in_vec={-256,0,0,0}.
  - Hidden pre-ReLU = {12,-20,-15} → {12,0,0}.
  - out_vec={-1,0}; checks floor shift of -60 to -1.
- Pipelining: Sample 0 and Sample 1 on consecutive cycles.
  - out_valid is high 2 consecutive cycles, giving {-19,37} then {-9,28}.
  - out_valid is low before and after.
- Reset mid-flight:
  - Apply in_valid, then drop rst_n before any clk edge: out_valid stays 0, out_vec=0.
  - Release rst_n, then present an all-zero input: out_vec={0,0}.
- Overflow:
  - Set W1 all 32767 and in_vec all 32767.
  - With NN_SAT_EN: hidden saturates at 32767. Output = (W2·h)>>>8, saturated.
  - Without NN_SAT_EN: wrapped low 16 bits, checked against a reference model.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and arithmetic helpers for the two-layer network.
//
// Contents:
//   DEF_WIDTH / DEF_FRAC : default word width and fractional bits (Q8.8)
//   acc_width(n, w)      : accumulator width that cannot overflow when n
//                          products of two w-bit signed words are summed
//   sat_narrow(v, w)     : narrow a value to w bits, returned sign-extended
//                          to 64 bits.
//                          NN_SAT_EN defined   -> saturate to the w-bit range
//                          NN_SAT_EN undefined -> keep the low w bits (wrap)
//   relu(v)              : clamp negative values to zero
package nn_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 8;

   function automatic int acc_width(input int n, input int w);
      return 2 * w + $clog2(n) + 1;
   endfunction

   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                     input int w);
`ifdef NN_SAT_EN
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
`else
      // Drop everything above bit w-1, then sign-extend from bit w-1.
      return (v <<< (64 - w)) >>> (64 - w);
`endif
   endfunction

   function automatic logic signed [63:0] relu(input logic signed [63:0] v);
      return (v < 64'sd0) ? 64'sd0 : v;
   endfunction

endpackage

// File: rtl/nn_dense_layer.sv
// nn_dense_layer: combinational fully-connected layer.
//   y[k] = narrow( (sum_i w[k][i] * x[i]) >>> FRAC ), optionally ReLU'd.
// The shift is a plain arithmetic shift (rounds toward minus infinity).
// Narrowing wraps or saturates depending on NN_SAT_EN (see nn_pkg).
//
// Parameters: N_IN, N_OUT, WIDTH, FRAC, RELU (1 = apply ReLU after narrowing)
// Ports:
//   x [N_IN]        in  signed input vector
//   w [N_OUT][N_IN] in  signed weights, row k feeds output k
//   y [N_OUT]       out signed result vector
module nn_dense_layer
   import nn_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3,
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC,
   parameter bit RELU  = 1'b0
) (
   input  logic signed [WIDTH-1:0] x [N_IN],
   input  logic signed [WIDTH-1:0] w [N_OUT][N_IN],
   output logic signed [WIDTH-1:0] y [N_OUT]
);

   localparam int ACC_W = acc_width(N_IN, WIDTH);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   acc;
   logic signed [63:0]        wide;

   always_comb begin
      prod = '0;
      acc  = '0;
      wide = '0;
      for (int k = 0; k < N_OUT; k++) begin
         acc = '0;
         for (int i = 0; i < N_IN; i++) begin
            // Full-precision product; accumulator is wide enough for the sum.
            prod = (2*WIDTH)'(x[i]) * (2*WIDTH)'(w[k][i]);
            acc  = acc + ACC_W'(prod);
         end
         wide = 64'(acc >>> FRAC);
         if (RELU) y[k] = WIDTH'(relu(sat_narrow(wide, WIDTH)));
         else      y[k] = WIDTH'(sat_narrow(wide, WIDTH));
      end
   end

endmodule

// File: rtl/neural_network_2_layer.sv
// neural_network_2_layer: pipelined dense -> ReLU -> dense inference block.
// Latency 2 cycles, one sample per cycle, no backpressure.
// Optional build macro: NN_SAT_EN (saturating narrowing instead of wrap).
//
// Handshake: a sample is accepted on every rising edge where in_valid=1;
// out_valid is a one-cycle strobe per result, results emerge in order.
// W1 is used in the cycle in_valid is high, W2 one cycle later.
//
// Ports:
//   clk, rst_n (async, active low)
//   in_valid, in_vec[1][IN_SIZE]      input sample
//   W1[HIDDEN1][IN_SIZE]              layer-1 weights
//   W2[OUT_SIZE][HIDDEN1]             layer-2 weights
//   out_valid, out_vec[1][OUT_SIZE]   inference result
module neural_network_2_layer
   import nn_pkg::*;
#(
   parameter int IN_SIZE  = 4,
   parameter int HIDDEN1  = 3,
   parameter int OUT_SIZE = 2,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC     = DEF_FRAC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_vec  [1][IN_SIZE],
   input  logic signed [WIDTH-1:0] W1      [HIDDEN1][IN_SIZE],
   input  logic signed [WIDTH-1:0] W2      [OUT_SIZE][HIDDEN1],
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_vec [1][OUT_SIZE]
);

   logic signed [WIDTH-1:0] h_next [HIDDEN1];
   logic signed [WIDTH-1:0] h      [HIDDEN1];
   logic                    h_valid;
   logic signed [WIDTH-1:0] o_next [OUT_SIZE];

   nn_dense_layer #(
      .N_IN(IN_SIZE), .N_OUT(HIDDEN1), .WIDTH(WIDTH), .FRAC(FRAC), .RELU(1'b1)
   ) u_layer1 (
      .x(in_vec[0]),
      .w(W1),
      .y(h_next)
   );

   nn_dense_layer #(
      .N_IN(HIDDEN1), .N_OUT(OUT_SIZE), .WIDTH(WIDTH), .FRAC(FRAC), .RELU(1'b0)
   ) u_layer2 (
      .x(h),
      .w(W2),
      .y(o_next)
   );

   // Data registers only load on valid so they hold between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_valid   <= 1'b0;
         out_valid <= 1'b0;
         for (int j = 0; j < HIDDEN1; j++)  h[j]          <= '0;
         for (int k = 0; k < OUT_SIZE; k++) out_vec[0][k] <= '0;
      end else begin
         h_valid   <= in_valid;
         out_valid <= h_valid;
         if (in_valid)
            for (int j = 0; j < HIDDEN1; j++)  h[j]          <= h_next[j];
         if (h_valid)
            for (int k = 0; k < OUT_SIZE; k++) out_vec[0][k] <= o_next[k];
      end
   end

endmodule

// File: tb/tb_neural_network_2_layer.sv
module tb_neural_network_2_layer;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic signed [15:0]  in_vec  [1][4];
   logic signed [15:0]  W1      [3][4];
   logic signed [15:0]  W2      [2][3];
   logic                out_valid;
   logic signed [15:0]  out_vec [1][2];

   always #5 clk = ~clk;

   neural_network_2_layer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
      .W1(W1), .W2(W2), .out_valid(out_valid), .out_vec(out_vec)
   );

   typedef struct packed {
      logic [3:0][15:0] x;
      logic [31:0]      e;   // {out0, out1}
   } vec_t;

   logic [31:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   int w1_init [3][4] = '{'{-12, -47, 11, 65}, '{20, -18, 21, 3}, '{15, 56, -4, 23}};
   int w2_init [2][3] = '{'{-5, -6, -17}, '{18, 38, 19}};

   function automatic vec_t mk(input int a, input int b, input int c, input int d,
                               input int e0, input int e1);
      vec_t v;
      v.x[0] = 16'(a); v.x[1] = 16'(b); v.x[2] = 16'(c); v.x[3] = 16'(d);
      v.e    = {16'(e0), 16'(e1)};
      return v;
   endfunction

   function automatic longint narrow16(input longint v);
      logic [63:0] t;
`ifdef NN_SAT_EN
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
`else
      t = 64'(v);
      return longint'($signed(t[15:0]));
`endif
   endfunction

   // Independent reference for arbitrary weights/inputs (uses current W1/W2).
   function automatic logic [31:0] model(input logic [3:0][15:0] x);
      longint hv [3];
      longint s;
      longint o [2];
      for (int j = 0; j < 3; j++) begin
         s = 0;
         for (int i = 0; i < 4; i++)
            s += longint'(W1[j][i]) * longint'($signed(x[i]));
         hv[j] = narrow16(s >>> 8);
         if (hv[j] < 0) hv[j] = 0;
      end
      for (int k = 0; k < 2; k++) begin
         s = 0;
         for (int j = 0; j < 3; j++) s += longint'(W2[k][j]) * hv[j];
         o[k] = narrow16(s >>> 8);
      end
      return {16'(o[0]), 16'(o[1])};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic load_common_weights();
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 4; i++) W1[j][i] = 16'(w1_init[j][i]);
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 3; j++) W2[k][j] = 16'(w2_init[k][j]);
   endtask

   task automatic drive(input logic [3:0][15:0] x, input logic [31:0] e);
      @(negedge clk);
      for (int i = 0; i < 4; i++) in_vec[0][i] = x[i];
      in_valid = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (exp_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Scoreboard: every out_valid strobe pops one expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
         end else begin
            check("out_vec", {out_vec[0][0], out_vec[0][1]}, exp_q.pop_front());
         end
      end
   end

   vec_t tbl [5];
   vec_t s0, s1, zv;

   initial begin
      for (int i = 0; i < 4; i++) in_vec[0][i] = '0;
      load_common_weights();

      tbl[0] = mk(256, 512, 768, 1024, -19, 37);
      tbl[1] = mk(512, -256, 0, 768, -9, 28);
      tbl[2] = mk(-256, 0, 0, 0, -1, 0);
      tbl[3] = mk(0, 0, 0, 0, 0, 0);
      tbl[4] = mk(-32768, 0, 0, 0, -30, 108);
      s0 = tbl[0];
      s1 = tbl[1];
      zv = tbl[3];

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_vec", {out_vec[0][0], out_vec[0][1]}, 32'd0);
      rst_n = 1'b1;

      // Table: single samples
      for (int n = 0; n < 5; n++) begin
         drive(tbl[n].x, tbl[n].e);
         drain();
      end

      // Back-to-back samples and exact latency
      check("pipe_idle_before", 32'(out_valid), 32'd0);
      drive(s0.x, s0.e);
      drive(s1.x, s1.e);
      check("pipe_lat_edge1", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("pipe_valid_first", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("pipe_valid_second", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("pipe_idle_after", 32'(out_valid), 32'd0);
      drain();

      // Reset while a sample is in flight
      @(negedge clk);
      for (int i = 0; i < 4; i++) in_vec[0][i] = s0.x[i];
      in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(out_valid), 32'd0);
      check("rst_async_vec", {out_vec[0][0], out_vec[0][1]}, 32'd0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_held_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_valid", 32'(out_valid), 32'd0);
      drive(zv.x, zv.e);
      drain();

      // Overflow: large weights and inputs
      @(negedge clk);
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 4; i++) W1[j][i] = 16'sd32767;
      begin
         logic [3:0][15:0] big;
         for (int i = 0; i < 4; i++) big[i] = 16'h7fff;
         drive(big, model(big));
      end
      drain();

      // Overflow with inputs that make the hidden layer exceed range positively
      begin
         logic [3:0][15:0] mix;
         load_common_weights();
         for (int i = 0; i < 4; i++) W1[0][i] = 16'sd32767;
         mix[0] = 16'h7fff; mix[1] = 16'h4000; mix[2] = 16'h0100; mix[3] = 16'h8000;
         drive(mix, model(mix));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=expired required=finished");
      $fatal(1, "timeout");
   end

endmodule
